// File: rtl/ecliptic_fcmp_pkg.sv
// ecliptic_fcmp_pkg
//   Shared definitions for the FP comparison issue/writeback stage:
//   the op encoding, the canonical quiet NaN, fflags bit positions and
//   local NaN classification helpers.
package ecliptic_fcmp_pkg;

  typedef enum logic [2:0] {
    FCMP_MIN = 3'd0,
    FCMP_MAX = 3'd1,
    FCMP_EQ  = 3'd2,
    FCMP_LT  = 3'd3,
    FCMP_LE  = 3'd4
  } fcmp_op_e;

  localparam logic [31:0] CANONICAL_NAN = 32'h7FC0_0000;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} exception vector.
  localparam int FFLAG_NV = 4;
  localparam int FFLAG_DZ = 3;
  localparam int FFLAG_OF = 2;
  localparam int FFLAG_UF = 1;
  localparam int FFLAG_NX = 0;

  // Per-operand classification carried alongside an op.
  typedef struct packed {
    logic nan;
    logic snan;
  } fcmp_class_t;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // A signalling NaN has the quiet bit (mantissa MSB) clear.
  function automatic logic is_snan(input logic [31:0] f);
    return is_nan(f) && !f[22];
  endfunction

  function automatic fcmp_class_t classify(input logic [31:0] f);
    fcmp_class_t c;
    c.nan  = is_nan(f);
    c.snan = is_snan(f);
    return c;
  endfunction

endpackage

// File: rtl/ecliptic_fcmp_fifo.sv
// ecliptic_fcmp_fifo
//   Parameterised synchronous FIFO with a registered head.
//   The head word lives in its own register so rdata never comes through
//   the storage read mux; it is held stable until a pop.
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   push, wdata   write request and data (ignored when full)
//   pop           read request (ignored when empty)
//   rdata         head entry (valid while ~empty)
//   empty, full   status flags
module ecliptic_fcmp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] head;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = head;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // Keep head equal to the oldest stored entry. On a pop with more
      // than one entry the next entry is already in storage; with exactly
      // one entry only a same-cycle write can refill the head.
      if (do_pop) begin
        if (count > (AW+1)'(1)) begin
          head <= mem[rd_ptr + AW'(1)];
        end else if (do_push) begin
          head <= wdata;
        end
      end else if (do_push && empty) begin
        head <= wdata;
      end
    end
  end

endmodule

// File: rtl/ecliptic_fcmp_issue.sv
// ecliptic_fcmp_issue
//   Issue and writeback stage around the single-precision FP comparison
//   unit. Ops are registered, sent to the unit one cycle later, and the
//   unit's one-cycle-latency results are merged with locally computed NaN
//   information to form the architectural result and NV flag. Tagged
//   results queue in a FIFO toward FP writeback, in acceptance order.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready/in_op/in_src1/in_src2/in_tag   op input
//   cmp_req/cmp_src1/cmp_src2        request to the comparison unit
//   cmp_minimum/cmp_maximum/cmp_lt/cmp_le/cmp_eq/cmp_ack   unit results
//   out_valid/out_ready/out_result/out_tag/out_fflags      result output
//
// Handshake: a transfer happens on a rising edge where valid & ready are
// both high; valid never waits on ready, and in_ready depends only on the
// local occupancy count (never combinationally on out_ready).
module ecliptic_fcmp_issue
  import ecliptic_fcmp_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             cmp_req,
  output logic [31:0]      cmp_src1,
  output logic [31:0]      cmp_src2,
  input  logic [31:0]      cmp_minimum,
  input  logic [31:0]      cmp_maximum,
  input  logic             cmp_lt,
  input  logic             cmp_le,
  input  logic             cmp_eq,
  input  logic             cmp_ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_fflags
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 32 + TAG_W + 5;

  // Ops accepted but not yet popped: issue register + unit + FIFO.
  // Bounding this by DEPTH guarantees a FIFO write never finds it full.
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             pop;

  // Issue register (feeds the unit).
  logic             iss_valid;
  logic [2:0]       iss_op;
  logic [TAG_W-1:0] iss_tag;
  logic [31:0]      iss_src1;
  logic [31:0]      iss_src2;
  fcmp_class_t      iss_cls1;
  fcmp_class_t      iss_cls2;

  // Metadata register, aligned with cmp_ack.
  logic             md_valid;
  logic [2:0]       md_op;
  logic [TAG_W-1:0] md_tag;
  logic [31:0]      md_src1;
  logic [31:0]      md_src2;
  fcmp_class_t      md_cls1;
  fcmp_class_t      md_cls2;

  logic [31:0]      res;
  logic [4:0]       flags;
  logic             any_nan;
  logic             fifo_push;
  logic             fifo_empty;
  logic             fifo_full;
  logic [ENT_W-1:0] fifo_head;

  assign in_ready = ~rst & (cnt < CNT_W'(DEPTH));
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;

  assign cmp_req  = iss_valid;
  assign cmp_src1 = iss_src1;
  assign cmp_src2 = iss_src2;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_valid <= 1'b0;
      iss_op    <= '0;
      iss_tag   <= '0;
      iss_src1  <= '0;
      iss_src2  <= '0;
      iss_cls1  <= '0;
      iss_cls2  <= '0;
    end else begin
      iss_valid <= accept;
      if (accept) begin
        iss_op   <= in_op;
        iss_tag  <= in_tag;
        iss_src1 <= in_src1;
        iss_src2 <= in_src2;
        iss_cls1 <= classify(in_src1);
        iss_cls2 <= classify(in_src2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_valid <= 1'b0;
      md_op    <= '0;
      md_tag   <= '0;
      md_src1  <= '0;
      md_src2  <= '0;
      md_cls1  <= '0;
      md_cls2  <= '0;
    end else begin
      md_valid <= iss_valid;
      if (iss_valid) begin
        md_op   <= iss_op;
        md_tag  <= iss_tag;
        md_src1 <= iss_src1;
        md_src2 <= iss_src2;
        md_cls1 <= iss_cls1;
        md_cls2 <= iss_cls2;
      end
    end
  end

  // Result formation. NaN handling uses only the local classification;
  // the unit's outputs are used only when both operands are numbers.
  assign any_nan = md_cls1.nan | md_cls2.nan;

  always_comb begin
    res   = '0;
    flags = '0;
    case (md_op)
      FCMP_MIN, FCMP_MAX: begin
        if (md_cls1.nan && md_cls2.nan) begin
          res = CANONICAL_NAN;
        end else if (md_cls1.nan) begin
          res = md_src2;
        end else if (md_cls2.nan) begin
          res = md_src1;
        end else if (md_op == FCMP_MIN) begin
          res = cmp_minimum;
        end else begin
          res = cmp_maximum;
        end
        flags[FFLAG_NV] = md_cls1.snan | md_cls2.snan;
      end
      FCMP_EQ: begin
        res[0]          = ~any_nan & cmp_eq;
        flags[FFLAG_NV] = md_cls1.snan | md_cls2.snan;
      end
      FCMP_LT: begin
        res[0]          = ~any_nan & cmp_lt;
        flags[FFLAG_NV] = any_nan;
      end
      FCMP_LE: begin
        res[0]          = ~any_nan & cmp_le;
        flags[FFLAG_NV] = any_nan;
      end
      default: begin
        res   = '0;
        flags = '0;
      end
    endcase
  end

  // An ack with no metadata behind it is a stray and is dropped. The
  // full check is redundant with the cnt bound but keeps the FIFO safe.
  assign fifo_push = md_valid & cmp_ack & ~fifo_full;

  ecliptic_fcmp_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({res, md_tag, flags}),
    .pop   (pop),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign out_valid                           = ~fifo_empty;
  assign {out_result, out_tag, out_fflags}   = fifo_head;

endmodule

// File: tb/tb_ecliptic_fcmp_issue.sv
// tb_ecliptic_fcmp_issue
//   Self-checking bench: a behavioural comparison unit (which returns
//   garbage whenever an operand is NaN), an IEEE/RISC-V reference model
//   feeding an expected-result queue, and directed plus random steps.
module tb_ecliptic_fcmp_issue;

  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
  localparam int W     = 32 + TAG_W + 5;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  always #5 clk = ~clk;

  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_op = '0;
  logic [31:0]      in_src1 = '0;
  logic [31:0]      in_src2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             cmp_req;
  logic [31:0]      cmp_src1, cmp_src2;
  logic [31:0]      cmp_minimum = '0, cmp_maximum = '0;
  logic             cmp_lt = 1'b0, cmp_le = 1'b0, cmp_eq = 1'b0, cmp_ack = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [4:0]       out_fflags;

  ecliptic_fcmp_issue #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .cmp_req(cmp_req), .cmp_src1(cmp_src1), .cmp_src2(cmp_src2),
    .cmp_minimum(cmp_minimum), .cmp_maximum(cmp_maximum),
    .cmp_lt(cmp_lt), .cmp_le(cmp_le), .cmp_eq(cmp_eq), .cmp_ack(cmp_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_fflags(out_fflags)
  );

  // ---------------- float helpers ----------------
  // Maps a float to an unsigned key whose order is the numeric order
  // (with -0 just below +0).
  function automatic logic [31:0] fkey(input logic [31:0] a);
    return a[31] ? ~a : (a | 32'h8000_0000);
  endfunction
  function automatic logic f_isnan(input logic [31:0] a);
    return (a[30:23] == 8'hFF) && (a[22:0] != 0);
  endfunction
  function automatic logic f_zeros(input logic [31:0] a, input logic [31:0] b);
    return (a[30:0] == 0) && (b[30:0] == 0);
  endfunction
  function automatic logic f_eq(input logic [31:0] a, input logic [31:0] b);
    return f_zeros(a, b) || (a == b);
  endfunction
  function automatic logic f_lt(input logic [31:0] a, input logic [31:0] b);
    return !f_zeros(a, b) && (fkey(a) < fkey(b));
  endfunction
  function automatic logic [31:0] f_min(input logic [31:0] a, input logic [31:0] b);
    return (fkey(a) <= fkey(b)) ? a : b;
  endfunction
  function automatic logic [31:0] f_max(input logic [31:0] a, input logic [31:0] b);
    return (fkey(a) >= fkey(b)) ? a : b;
  endfunction

  // ---------------- comparison unit model ----------------
  always @(posedge clk) begin
    cmp_ack <= cmp_req;
    if (f_isnan(cmp_src1) || f_isnan(cmp_src2)) begin
      cmp_minimum <= $urandom;
      cmp_maximum <= $urandom;
      cmp_lt      <= 1'($urandom);
      cmp_le      <= 1'($urandom);
      cmp_eq      <= 1'($urandom);
    end else begin
      cmp_minimum <= f_min(cmp_src1, cmp_src2);
      cmp_maximum <= f_max(cmp_src1, cmp_src2);
      cmp_lt      <= f_lt(cmp_src1, cmp_src2);
      cmp_le      <= f_lt(cmp_src1, cmp_src2) || f_eq(cmp_src1, cmp_src2);
      cmp_eq      <= f_eq(cmp_src1, cmp_src2);
    end
  end

  // ---------------- reference model ----------------
  // Returns {result[31:0], fflags[4:0]}.
  function automatic logic [36:0] ref_model(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    logic na, nb, sa, sb;
    logic [31:0] r;
    logic nv;
    na = f_isnan(a);
    nb = f_isnan(b);
    sa = na && !a[22];
    sb = nb && !b[22];
    r  = 32'd0;
    nv = 1'b0;
    case (op)
      3'd0, 3'd1: begin
        if (na && nb)  r = 32'h7FC0_0000;
        else if (na)   r = b;
        else if (nb)   r = a;
        else           r = (op == 3'd0) ? f_min(a, b) : f_max(a, b);
        nv = sa || sb;
      end
      3'd2: begin r = {31'd0, !na && !nb && f_eq(a, b)}; nv = sa || sb; end
      3'd3: begin r = {31'd0, !na && !nb && f_lt(a, b)}; nv = na || nb; end
      3'd4: begin
        r  = {31'd0, !na && !nb && (f_lt(a, b) || f_eq(a, b))};
        nv = na || nb;
      end
      default: begin r = 32'd0; nv = 1'b0; end
    endcase
    return {r, nv, 4'b0000};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 9))
      0: v = 32'h7FC0_0000 | ($urandom & 32'h003F_FFFF);
      1: v = 32'h7F80_0001 | ($urandom & 32'h003F_FFFF);
      2: v = 32'h0000_0000;
      3: v = 32'h7F80_0000;
      4: v = 32'h3F80_0000;
      5: v = 32'h4000_0000;
      default: v = $urandom;
    endcase
    if ($urandom_range(0, 1) == 1) v[31] = ~v[31];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_acc   = 0;
  logic         last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: record accept/pop seen before the edge, then advance.
  task automatic cycle();
    logic [36:0]  m;
    logic [W-1:0] e;
    #1;
    last_acc = 1'b0;
    if (in_valid === 1'b1 && in_ready === 1'b1) begin
      m = ref_model(in_op, in_src1, in_src2);
      exp_q.push_back({m[36:5], in_tag, m[4:0]});
      last_acc = 1'b1;
      n_acc++;
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'(out_result), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        check("sb_result", 64'(out_result), 64'(e[W-1 -: 32]));
        check("sb_tag",    64'(out_tag),    64'(e[TAG_W+4:5]));
        check("sb_fflags", 64'(out_fflags), 64'(e[4:0]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_one(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic [4:0] exp_fl);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = 5'd9;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid === 1'b1) break;
      cycle();
    end
    check({name, "_valid"},  64'(out_valid),  64'd1);
    check({name, "_result"}, 64'(out_result), 64'(exp_res));
    check({name, "_fflags"}, 64'(out_fflags), 64'(exp_fl));
    cycle();
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (exp_q.size() != 0 || out_valid === 1'b1); i++) cycle();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_cmp_req"},  64'(cmp_req),    64'd0);
    check({name, "_cmp_src1"}, 64'(cmp_src1),   64'd0);
    check({name, "_cmp_src2"}, 64'(cmp_src2),   64'd0);
    check({name, "_out_valid"},64'(out_valid),  64'd0);
    check({name, "_out_result"},64'(out_result),64'd0);
    check({name, "_out_tag"},  64'(out_tag),    64'd0);
    check({name, "_out_fflags"},64'(out_fflags),64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bp_acc;

    // Reset
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("rst_in_ready", 64'(in_ready), 64'd0);
    end
    check_reset_outputs("rst");
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // FLT 1.0 < 2.0, latency
    in_valid = 1'b1; in_op = 3'd3; in_src1 = 32'h3F80_0000; in_src2 = 32'h4000_0000; in_tag = 5'd3;
    cycle();
    in_valid = 1'b0;
    check("flt_accept",   64'(last_acc),  64'd1);
    check("flt_cmp_req",  64'(cmp_req),   64'd1);
    check("flt_cmp_src1", 64'(cmp_src1),  64'h3F80_0000);
    check("flt_valid_t1", 64'(out_valid), 64'd0);
    cycle();
    check("flt_valid_t2", 64'(out_valid), 64'd0);
    cycle();
    check("flt_valid_t3", 64'(out_valid), 64'd1);
    check("flt_result",   64'(out_result),64'd1);
    check("flt_tag",      64'(out_tag),   64'd3);
    check("flt_fflags",   64'(out_fflags),64'd0);
    cycle();

    // NaN rules
    run_one("fmin_snan", 3'd0, 32'h7FA0_0000, 32'hBF80_0000, 32'hBF80_0000, 5'h10);
    run_one("fmax_qq",   3'd1, 32'h7FC0_0000, 32'h7FC0_0000, 32'h7FC0_0000, 5'h00);
    run_one("fle_qnan",  3'd4, 32'h7FC0_0000, 32'h3F80_0000, 32'd0,         5'h10);
    run_one("feq_qnan",  3'd2, 32'h7FC0_0000, 32'h3F80_0000, 32'd0,         5'h00);
    run_one("feq_zeros", 3'd2, 32'h8000_0000, 32'h0000_0000, 32'd1,         5'h00);
    run_one("fmin_zero", 3'd0, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 5'h00);
    run_one("illegal",   3'd6, 32'h7FA0_0000, 32'h3F80_0000, 32'd0,         5'h00);

    // Backpressure: exactly DEPTH accepts
    out_ready = 1'b0;
    in_valid  = 1'b1;
    bp_acc    = 0;
    for (int i = 0; i < 8; i++) begin
      in_tag = TAG_W'(bp_acc); in_op = 3'($urandom_range(0, 4));
      in_src1 = rand_operand(); in_src2 = rand_operand();
      cycle();
      if (last_acc) bp_acc++;
    end
    check("bp_accepts",  64'(bp_acc),   64'(DEPTH));
    check("bp_in_ready", 64'(in_ready), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      check("bp_pop_valid", 64'(out_valid), 64'd1);
      check("bp_pop_tag",   64'(out_tag),   64'(i));
      cycle();
      if (i == 0) check("bp_ready_after_pop", 64'(in_ready), 64'd1);
    end
    check("bp_drained", 64'(out_valid), 64'd0);

    // Streaming 16 ops
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_tag = TAG_W'(i); in_op = 3'($urandom_range(0, 4));
      in_src1 = rand_operand(); in_src2 = rand_operand();
      #1;
      check("stream_in_ready", 64'(in_ready), 64'd1);
      if (i >= 3) check("stream_out_valid", 64'(out_valid), 64'd1);
      cycle();
    end
    drain();

    // Random traffic incl. illegal ops
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
      in_src1   = rand_operand();
      in_src2   = ($urandom_range(0, 4) == 0) ? in_src1 : rand_operand();
      cycle();
    end
    drain();

    // Reset while an op is in the unit
    in_valid = 1'b1; in_op = 3'd3; in_src1 = 32'h3F80_0000; in_src2 = 32'h4000_0000; in_tag = 5'd7;
    cycle();
    in_valid = 1'b0;
    check("mid_cmp_req", 64'(cmp_req), 64'd1);
    cycle();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    cycle();
    exp_q.delete();
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    check("mid_post_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("mid_no_result", 64'(out_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
